// File: rtl/bm_fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding and
// parameter defaults.
package bm_fifo_uart_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int FRAME_COUNT_W    = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        LATCH  = ST_LATCH,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; tick marks the last cycle of a serial bit,
// restart realigns the count to 0 on every FSM state change.
module uart_bit_timer
    import bm_fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot matter.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/bm_fifo_uart_tx.sv
// UART transmitter that pulls one word per frame from an upstream synchronous
// FIFO (one-cycle read latency) and serialises it LSB first.
module bm_fifo_uart_tx
    import bm_fifo_uart_tx_pkg::*;
#(
    parameter int                        CLKS_PER_BIT     = DEF_CLKS_PER_BIT,
    parameter int                        DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter bit                        PARITY_EN        = 1'b0,
    // Value frame_count takes on reset; left at 0 outside of wrap testing.
    parameter logic [FRAME_COUNT_W-1:0]  FRAME_COUNT_INIT = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fifo_empty,
    input  logic [DATA_WIDTH-1:0]    fifo_data,
    output logic                     fifo_read_n,
    output logic                     tx,
    output logic                     busy,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam int               IDX_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [DATA_WIDTH-1:0]    w_shift_next;
    logic [IDX_W-1:0]         r_bit_idx;
    logic                     r_parity;
    logic                     r_tx;
    logic                     w_tx_next;
    logic                     w_tick;
    logic                     w_restart;
    logic [FRAME_COUNT_W-1:0] r_frame_count;

    assign w_restart = (w_next_state != r_state);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_shift_next = r_shift;
        w_tx_next    = 1'b1;

        case (r_state)
            IDLE:    if (!fifo_empty) w_next_state = FETCH;
            FETCH:   w_next_state = LATCH;
            LATCH:   w_next_state = START;
            START:   if (w_tick) w_next_state = DATA;
            DATA:    if (w_tick && r_bit_idx == LAST_BIT)
                         w_next_state = PARITY_EN ? PARITY : STOP;
            PARITY:  if (w_tick) w_next_state = STOP;
            STOP:    if (w_tick) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase

        if (r_state == LATCH) begin
            w_shift_next = fifo_data;
        end else if (r_state == DATA && w_tick) begin
            w_shift_next = r_shift >> 1;
        end

        // tx is registered from next-state values so the line changes exactly
        // on the edge that enters each bit period.
        case (w_next_state)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = r_parity;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_parity      <= 1'b0;
            r_tx          <= 1'b1;
            r_frame_count <= FRAME_COUNT_INIT;
        end else begin
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            if (r_state == LATCH) begin
                r_parity  <= ^fifo_data;
                r_bit_idx <= '0;
            end else if (r_state == DATA && w_tick) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (r_state == STOP && w_tick) begin
                r_frame_count <= r_frame_count + FRAME_COUNT_W'(1);
            end
        end
    end

    assign fifo_read_n = (r_state != FETCH);
    assign busy        = (r_state != IDLE);
    assign tx          = r_tx;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_bm_fifo_uart_tx.sv
// Scoreboard bench: channel 0 is an 8N1 transmitter, channel 1 adds even parity
// and starts its frame counter two below the wrap point.
module tb_bm_fifo_uart_tx;

    localparam int CPB = 4;

    typedef struct packed {
        logic [10:0] frame;    // line bits in send order, bit 0 = start bit
        logic [15:0] count;    // frame_count expected once this frame ends
        logic        aborted;  // frame is expected to be cut short by reset
    } exp_t;

    logic        clock = 1'b0;
    logic        rst     [2];
    logic        fempty  [2];
    logic [7:0]  fdata   [2];
    logic        rd_n    [2];
    logic        tx_w    [2];
    logic        busy_w  [2];
    logic [15:0] fc_w    [2];

    logic [7:0]  fq      [2][$];
    exp_t        exp_q   [2][$];
    int          strobes [2][$];

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          mon_pos  [2] = '{-1, -1};
    int          hold_err [2] = '{0, 0};
    logic [10:0] obs      [2];
    bit          fc_pend  [2] = '{1'b0, 1'b0};
    logic [15:0] fc_exp   [2];

    always #5 clock = ~clock;

    bm_fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_WIDTH   (8),
        .PARITY_EN    (1'b0)
    ) dut0 (
        .clock       (clock),
        .reset       (rst[0]),
        .fifo_empty  (fempty[0]),
        .fifo_data   (fdata[0]),
        .fifo_read_n (rd_n[0]),
        .tx          (tx_w[0]),
        .busy        (busy_w[0]),
        .frame_count (fc_w[0])
    );

    bm_fifo_uart_tx #(
        .CLKS_PER_BIT     (CPB),
        .DATA_WIDTH       (8),
        .PARITY_EN        (1'b1),
        .FRAME_COUNT_INIT (16'hFFFE)
    ) dut1 (
        .clock       (clock),
        .reset       (rst[1]),
        .fifo_empty  (fempty[1]),
        .fifo_data   (fdata[1]),
        .fifo_read_n (rd_n[1]),
        .tx          (tx_w[1]),
        .busy        (busy_w[1]),
        .frame_count (fc_w[1])
    );

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input int c, input logic [7:0] data, input logic [10:0] frame,
                        input logic [15:0] count, input bit aborted);
        exp_t e;
        e.frame   = frame;
        e.count   = count;
        e.aborted = aborted;
        exp_q[c].push_back(e);
        fq[c].push_back(data);
    endtask

    task automatic wait_drain(input int c, input int limit);
        int n = 0;
        while ((exp_q[c].size() != 0 || fc_pend[c]) && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("drain_in_time", n < limit, n, limit);
    endtask

    // Upstream FIFO: a strobe seen in one cycle updates fdata on the next edge.
    initial begin
        logic prev_rd [2];
        for (int c = 0; c < 2; c++) begin
            prev_rd[c] = 1'b1;
            fempty[c]  = 1'b1;
            fdata[c]   = 8'h00;
        end
        forever begin
            @(posedge clock);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (prev_rd[c] == 1'b0 && fq[c].size() != 0) fdata[c] = fq[c].pop_front();
                prev_rd[c] = rd_n[c];
                fempty[c]  = (fq[c].size() == 0);
            end
        end
    end

    // Monitor: tracks strobes, follows each frame cycle by cycle against the
    // scoreboard head, then checks frame_count in the first idle cycle.
    always @(negedge clock) begin
        exp_t cur;
        int   bi;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (rst[c]) begin
                if (mon_pos[c] >= 0) begin
                    cur = exp_q[c].pop_front();
                    check("abort_expected", cur.aborted, 0, 1);
                    mon_pos[c] = -1;
                end
                fc_pend[c] = 1'b0;
            end else begin
                if (rd_n[c] == 1'b0) begin
                    check("read_nonempty", fq[c].size() != 0, fq[c].size(), 1);
                    strobes[c].push_back(cyc);
                end
                if (fc_pend[c]) begin
                    check("frame_count", fc_w[c] == fc_exp[c], fc_w[c], fc_exp[c]);
                    check("idle_after_stop", busy_w[c] == 1'b0, busy_w[c], 0);
                    fc_pend[c] = 1'b0;
                end
                if (mon_pos[c] < 0 && tx_w[c] == 1'b0) begin
                    if (exp_q[c].size() == 0) begin
                        check("unexpected_start", 1'b0, c, 0);
                    end else begin
                        mon_pos[c]  = 0;
                        hold_err[c] = 0;
                        obs[c]      = '0;
                    end
                end
                if (mon_pos[c] >= 0) begin
                    cur = exp_q[c][0];
                    bi  = mon_pos[c] / CPB;
                    if (tx_w[c] != cur.frame[bi] || busy_w[c] != 1'b1) hold_err[c]++;
                    if (mon_pos[c] % CPB == CPB / 2) obs[c][bi] = tx_w[c];
                    mon_pos[c]++;
                    if (mon_pos[c] == ((c == 0) ? 10 : 11) * CPB) begin
                        void'(exp_q[c].pop_front());
                        check("frame_bits", obs[c] == cur.frame && !cur.aborted,
                              obs[c], cur.frame);
                        check("bit_hold", hold_err[c] == 0, hold_err[c], 0);
                        fc_exp[c]  = cur.count;
                        fc_pend[c] = 1'b1;
                        mon_pos[c] = -1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no summary after %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int v0 = 0;
        int v1 = 0;
        int n  = 0;
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // Idle: 50 cycles in reset, then 50 more with the FIFO still empty.
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (i == 50) begin
                rst[0] = 1'b0;
                rst[1] = 1'b0;
            end
            @(negedge clock);
            if (tx_w[0] !== 1'b1 || rd_n[0] !== 1'b1 || busy_w[0] !== 1'b0 || fc_w[0] !== 16'h0000) v0++;
            if (tx_w[1] !== 1'b1 || rd_n[1] !== 1'b1 || busy_w[1] !== 1'b0 || fc_w[1] !== 16'hFFFE) v1++;
        end
        check("idle_ch0", v0 == 0, v0, 0);
        check("idle_ch1", v1 == 0, v1, 0);

        // Reset during bit 0 of 8'h3C, then 8'hA5 must follow intact.
        @(posedge clock);
        #1;
        send(0, 8'h3C, 11'b0_1_00111100_0, 16'd0, 1'b1);
        send(0, 8'hA5, 11'b0_1_10100101_0, 16'd1, 1'b0);
        @(negedge clock);
        while (tx_w[0] != 1'b0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("start_seen", n < 40, n, 40);
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1;
        rst[0] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("abort_tx_high", tx_w[0] == 1'b1, tx_w[0], 1);
        check("abort_not_busy", busy_w[0] == 1'b0, busy_w[0], 0);
        check("abort_frame_count", fc_w[0] == 16'd0, fc_w[0], 0);
        @(posedge clock);
        #1;
        rst[0] = 1'b0;
        wait_drain(0, 200);
        check("strobes_after_a5", strobes[0].size() == 2, strobes[0].size(), 2);

        // Back-to-back bursts: three 8N1 words and two parity words across the wrap.
        @(posedge clock);
        #1;
        send(0, 8'h12, 11'b0_1_00010010_0, 16'd2, 1'b0);
        send(0, 8'hFF, 11'b0_1_11111111_0, 16'd3, 1'b0);
        send(0, 8'h00, 11'b0_1_00000000_0, 16'd4, 1'b0);
        send(1, 8'h07, 11'b1_1_00000111_0, 16'hFFFF, 1'b0);
        send(1, 8'hF0, 11'b1_0_11110000_0, 16'h0000, 1'b0);
        wait_drain(0, 500);
        wait_drain(1, 500);
        repeat (20) @(negedge clock);
        check("strobes_ch0", strobes[0].size() == 5, strobes[0].size(), 5);
        check("spacing_ch0_a", strobes[0][3] - strobes[0][2] == 43, strobes[0][3] - strobes[0][2], 43);
        check("spacing_ch0_b", strobes[0][4] - strobes[0][3] == 43, strobes[0][4] - strobes[0][3], 43);
        check("strobes_ch1", strobes[1].size() == 2, strobes[1].size(), 2);
        check("spacing_ch1", strobes[1][1] - strobes[1][0] == 47, strobes[1][1] - strobes[1][0], 47);
        check("final_count_ch1", fc_w[1] == 16'h0000, fc_w[1], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
